// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-port line arbiter in front of a single downstream memory port.
// One transaction outstanding at a time; winner chosen round-robin or by fixed priority.
module mem_arbiter_rr #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 128,
    parameter int PRIORITY_MODE = 0,
    localparam int GW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_resp,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [GW-1:0]                    grant_id,
    output logic                             busy,
    output logic [15:0]                      contention_count
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic                    op_read_q, op_read_d;
    logic                    op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [15:0]             contention_q, contention_d;

    logic [NUM_PORTS-1:0]    requesting;
    logic [GW-1:0]           winner;
    int                      n_req;
    int                      sel;

    // Scan from the highest offset down so the lowest offset from the start point wins.
    always_comb begin
        requesting = req_read | req_write;
        winner     = '0;
        n_req      = 0;
        sel        = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (requesting[i]) n_req++;
        end
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sel = (PRIORITY_MODE != 0) ? k : (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (requesting[GW'(sel)]) winner = GW'(sel);
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        op_read_d    = op_read_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        contention_d = contention_q;
        case (state_q)
            IDLE: begin
                if (|requesting) begin
                    grant_d    = winner;
                    // A port asserting both read and write gets only the write.
                    op_write_d = req_write[winner];
                    op_read_d  = ~req_write[winner];
                    addr_d     = req_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                    state_d    = BUSY;
                    if (n_req >= 2 && contention_q != 16'hFFFF) begin
                        contention_d = contention_q + 16'd1;
                    end
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d  = IDLE;
                    rr_ptr_d = GW'((int'(grant_q) + 1) % NUM_PORTS);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            op_read_q    <= 1'b0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            contention_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            op_read_q    <= op_read_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            contention_q <= contention_d;
        end
    end

    always_comb begin
        busy             = (state_q == BUSY);
        mem_read         = busy & op_read_q;
        mem_write        = busy & op_write_q;
        mem_address      = addr_q;
        mem_wdata        = wdata_q;
        grant_id         = grant_q;
        contention_count = contention_q;
        req_resp         = '0;
        req_rdata        = '0;
        if (busy && mem_resp) begin
            req_resp[grant_q] = 1'b1;
            req_rdata         = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr (RR and fixed-priority instances).
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   req_read, req_write, req_resp;
    logic [63:0]  req_address;
    logic [511:0] req_wdata;
    logic [127:0] req_rdata, mem_wdata, mem_rdata;
    logic         mem_read, mem_write, mem_resp, busy;
    logic [15:0]  mem_address, contention_count;
    logic [1:0]   grant_id;

    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(128), .PRIORITY_MODE(0)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .req_resp(req_resp),
        .req_rdata(req_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy),
        .contention_count(contention_count)
    );

    logic [2:0]   fp_req_read, fp_req_write, fp_req_resp;
    logic [35:0]  fp_req_address;
    logic [95:0]  fp_req_wdata;
    logic [31:0]  fp_req_rdata, fp_mem_wdata, fp_mem_rdata;
    logic         fp_mem_read, fp_mem_write, fp_mem_resp, fp_busy;
    logic [11:0]  fp_mem_address;
    logic [1:0]   fp_grant_id;
    logic [15:0]  fp_cc;

    mem_arbiter_rr #(.NUM_PORTS(3), .ADDR_WIDTH(12), .DATA_WIDTH(32), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .req_read(fp_req_read), .req_write(fp_req_write),
        .req_address(fp_req_address), .req_wdata(fp_req_wdata), .req_resp(fp_req_resp),
        .req_rdata(fp_req_rdata), .mem_read(fp_mem_read), .mem_write(fp_mem_write),
        .mem_address(fp_mem_address), .mem_wdata(fp_mem_wdata), .mem_resp(fp_mem_resp),
        .mem_rdata(fp_mem_rdata), .grant_id(fp_grant_id), .busy(fp_busy),
        .contention_count(fp_cc)
    );

    typedef struct {
        int           port;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } grant_t;

    typedef struct {
        logic [3:0]   resp;
        logic [127:0] rdata;
    } resp_t;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wr;
        int          port;
        logic        exp_wr;
        logic [15:0] cc;
        int          delay;
    } vec_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    vec_t   tbl[8];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] port_addr(input int i, input int k);
        return 16'((i + 1) * 256 + k);
    endfunction

    function automatic logic [127:0] port_wdata(input int i, input int k);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i * 256 + k);
        return {4{w}};
    endfunction

    function automatic logic [127:0] rline(input int k);
        logic [31:0] w;
        w = 32'hA000_0000 + 32'(k);
        return {4{w}};
    endfunction

    task automatic drive_ports(input logic [3:0] rd, input logic [3:0] wr, input int k);
        for (int i = 0; i < 4; i++) begin
            req_address[i*16 +: 16]  = port_addr(i, k);
            req_wdata[i*128 +: 128]  = port_wdata(i, k);
        end
        req_read  = rd;
        req_write = wr;
    endtask

    task automatic push_grant(input int port, input logic wr, input logic [15:0] addr,
                              input logic [127:0] wdata);
        grant_t g;
        g.port = port; g.wr = wr; g.addr = addr; g.wdata = wdata;
        grant_q.push_back(g);
    endtask

    task automatic serve(input int delay, input logic [127:0] rdata, input int port);
        resp_t r;
        repeat (delay) @(negedge clk);
        r.resp  = 4'b0001 << port;
        r.rdata = rdata;
        resp_q.push_back(r);
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard side: new transactions and completions popped as the DUT shows them.
    logic   busy_prev = 1'b0;
    grant_t mg;
    resp_t  mr;
    always @(negedge clk) begin
        #2;
        if (busy && !busy_prev) begin
            if (grant_q.size() == 0) begin
                check("unexpected_grant", 128'(busy), 128'd0);
            end else begin
                mg = grant_q.pop_front();
                check("sb_grant_id", 128'(grant_id), 128'(mg.port));
                check("sb_mem_read", 128'(mem_read), 128'(!mg.wr));
                check("sb_mem_write", 128'(mem_write), 128'(mg.wr));
                check("sb_mem_address", 128'(mem_address), 128'(mg.addr));
                if (mg.wr) check("sb_mem_wdata", mem_wdata, mg.wdata);
            end
        end
        busy_prev = busy;
        if (req_resp != 4'b0) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 128'(req_resp), 128'd0);
            end else begin
                mr = resp_q.pop_front();
                check("sb_req_resp", 128'(req_resp), 128'(mr.resp));
                check("sb_req_rdata", req_rdata, mr.rdata);
            end
        end else begin
            check("rdata_idle", req_rdata, 128'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [127:0] w39;
    logic [15:0]  exp_cc;
    int           p;

    initial begin
        tbl[0] = '{4'b0101, 4'b0000, 2, 1'b0, 16'd1, 0};
        tbl[1] = '{4'b0011, 4'b0010, 0, 1'b0, 16'd2, 1};
        tbl[2] = '{4'b0010, 4'b0010, 1, 1'b1, 16'd2, 2};
        tbl[3] = '{4'b0000, 4'b1001, 3, 1'b1, 16'd3, 0};
        tbl[4] = '{4'b1000, 4'b0100, 2, 1'b1, 16'd4, 1};
        tbl[5] = '{4'b0001, 4'b0000, 0, 1'b0, 16'd4, 2};
        tbl[6] = '{4'b1111, 4'b0000, 1, 1'b0, 16'd5, 0};
        tbl[7] = '{4'b0000, 4'b1000, 3, 1'b1, 16'd5, 1};

        req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        fp_req_read = '0; fp_req_write = '0; fp_req_address = '0; fp_req_wdata = '0;
        fp_mem_resp = 1'b0; fp_mem_rdata = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_mem_read", 128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_req_resp", 128'(req_resp), 128'd0);
        check("rst_grant_id", 128'(grant_id), 128'd0);
        check("rst_cc", 128'(contention_count), 128'd0);
        check("rst_mem_address", 128'(mem_address), 128'd0);

        // Single read from port 0, response three cycles after the strobe.
        @(negedge clk);
        rst = 1'b0;
        req_address[15:0] = 16'h1000;
        req_read = 4'b0001;
        push_grant(0, 1'b0, 16'h1000, '0);
        @(negedge clk);
        #1;
        check("r36_mem_read", 128'(mem_read), 128'd1);
        check("r36_mem_address", 128'(mem_address), 128'h1000);
        check("r36_busy", 128'(busy), 128'd1);
        check("r36_resp_early", 128'(req_resp), 128'd0);
        serve(3, {16{8'hA5}}, 0);
        #1;
        check("r36_busy_low", 128'(busy), 128'd0);
        req_read = '0;

        for (int k = 0; k < 8; k++) begin
            drive_ports(tbl[k].rd, tbl[k].wr, k);
            push_grant(tbl[k].port, tbl[k].exp_wr, port_addr(tbl[k].port, k),
                       port_wdata(tbl[k].port, k));
            @(negedge clk);
            #1;
            check("tbl_cc", 128'(contention_count), 128'(tbl[k].cc));
            check("tbl_busy", 128'(busy), 128'd1);
            serve(tbl[k].delay, rline(k), tbl[k].port);
            drive_ports(4'b0000, 4'b0000, k);
            #1;
            check("tbl_idle", 128'(busy), 128'd0);
        end

        // Payload must stay frozen while the requester changes its inputs.
        w39 = port_wdata(0, 39);
        req_address[15:0] = 16'h2000;
        req_wdata[127:0]  = w39;
        req_write = 4'b0001;
        push_grant(0, 1'b1, 16'h2000, w39);
        @(negedge clk);
        req_address[15:0] = 16'h3000;
        req_wdata[127:0]  = ~w39;
        req_write = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("r39_mem_address", 128'(mem_address), 128'h2000);
            check("r39_mem_wdata", mem_wdata, w39);
            check("r39_mem_write", 128'(mem_write), 128'd1);
            @(negedge clk);
        end
        serve(0, rline(39), 0);
        req_write = '0;

        // Reset during an outstanding port 1 read, with mem_resp high during reset.
        drive_ports(4'b0010, 4'b0000, 40);
        push_grant(1, 1'b0, port_addr(1, 40), '0);
        @(negedge clk);
        #1;
        check("r40_busy", 128'(busy), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = '1;
        #1;
        check("r40_req_resp", 128'(req_resp), 128'd0);
        check("r40_req_rdata", req_rdata, 128'd0);
        check("r40_busy_rst", 128'(busy), 128'd0);
        check("r40_mem_read", 128'(mem_read), 128'd0);
        check("r40_mem_address", 128'(mem_address), 128'd0);
        check("r40_grant_id", 128'(grant_id), 128'd0);
        check("r40_cc", 128'(contention_count), 128'd0);
        push_grant(1, 1'b0, port_addr(1, 40), '0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        #1;
        check("r40_regrant_busy", 128'(busy), 128'd1);
        serve(1, rline(40), 1);
        drive_ports(4'b0000, 4'b0000, 40);

        // All four ports requesting continuously: strict rotation.
        do_reset();
        drive_ports(4'b1111, 4'b0000, 20);
        for (int n = 0; n < 5; n++) begin
            push_grant(n % 4, 1'b0, port_addr(n % 4, 20), '0);
            @(negedge clk);
            serve(0, rline(50 + n), n % 4);
        end
        drive_ports(4'b0000, 4'b0000, 20);
        #1;
        check("r37_cc", 128'(contention_count), 128'd5);

        // Saturation of the contention counter.
        @(negedge clk);
        force dut.contention_q = 16'hFFFC;
        #1;
        release dut.contention_q;
        drive_ports(4'b1111, 4'b0000, 30);
        for (int n = 0; n < 4; n++) begin
            p = (1 + n) % 4;
            exp_cc = (n < 2) ? 16'(16'hFFFD + n) : 16'hFFFF;
            push_grant(p, 1'b0, port_addr(p, 30), '0);
            @(negedge clk);
            #1;
            check("r41_cc", 128'(contention_count), 128'(exp_cc));
            serve(0, rline(60 + n), p);
        end
        drive_ports(4'b0000, 4'b0000, 30);

        // Fixed priority instance.
        fp_req_address = {12'h320, 12'h210, 12'h100};
        fp_req_read = 3'b110;
        for (int n = 0; n < 5; n++) begin
            if (n == 4) fp_req_read = 3'b101;
            @(negedge clk);
            #1;
            check("fp_grant_id", 128'(fp_grant_id), (n == 4) ? 128'd0 : 128'd1);
            check("fp_mem_address", 128'(fp_mem_address), (n == 4) ? 128'h100 : 128'h210);
            check("fp_mem_read", 128'(fp_mem_read), 128'd1);
            fp_mem_resp  = 1'b1;
            fp_mem_rdata = 32'hC0DE_0000 + 32'(n);
            #1;
            check("fp_req_resp", 128'(fp_req_resp), (n == 4) ? 128'b001 : 128'b010);
            check("fp_req_rdata", 128'(fp_req_rdata), 128'(32'hC0DE_0000 + 32'(n)));
            @(negedge clk);
            fp_mem_resp  = 1'b0;
            fp_mem_rdata = '0;
        end
        fp_req_read = '0;
        @(negedge clk);
        #1;
        check("fp_cc", 128'(fp_cc), 128'd5);
        check("fp_busy_idle", 128'(fp_busy), 128'd0);

        @(negedge clk);
        #3;
        check("sb_grants_left", 128'(grant_q.size()), 128'd0);
        check("sb_resps_left", 128'(resp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
